// File: rtl/cosine_datapath_if.sv
// Handshake bundle between the cosine control unit (master) and the Taylor-series datapath (slave).
interface cosine_datapath_if #(
    parameter int WIDTH = 18
);
    logic [2:0]              state;
    logic signed [WIDTH-1:0] x_in;
    logic                    stop;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] err_out;
    logic                    done;

    modport master (output state, x_in, input stop, cos_out, err_out, done);
    modport slave  (input state, x_in, output stop, cos_out, err_out, done);
endinterface

// File: rtl/cosine_datapath.sv
// Fixed-point Taylor-series cosine datapath: t(k+1) = -t(k) * x^2 / ((2k+1)(2k+2)),
// sequenced by the control unit's state code; publishes cos(x) and a truncation-error bound.
module cosine_datapath #(
    parameter int WIDTH   = 18,
    parameter int FRAC    = 14,
    parameter int N_TERMS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cosine_datapath_if.slave   bus
);
    localparam logic [2:0] ST_ALERT   = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_ACCUM   = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;

    // x^2 reaches ~9.87 at x = pi, beyond the Q4.14 word, so x2 carries 4 guard bits.
    localparam int X2W = WIDTH + 4;
    localparam int TW  = 2 * WIDTH + 4;
    localparam int PW  = TW - FRAC;
    localparam int RW  = WIDTH + FRAC;

    localparam logic [3:0]              K_LAST = 4'(N_TERMS);
    localparam logic signed [WIDTH-1:0] ONE    = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] W_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH+1:0] A_MAX  = (WIDTH+2)'(W_MAX);
    localparam logic signed [WIDTH+1:0] A_MIN  = (WIDTH+2)'(W_MIN);

    typedef logic signed [WIDTH-1:0] recip_t [16];

    function automatic recip_t build_recip();
        recip_t r;
        int     d;
        for (int k = 0; k < 16; k++) begin
            d    = (2 * k + 1) * (2 * k + 2);
            r[k] = (k < N_TERMS) ? WIDTH'(((1 << (FRAC + 1)) / d + 1) / 2) : '0;
        end
        return r;
    endfunction

    localparam recip_t RECIP = build_recip();

    function automatic logic signed [WIDTH-1:0] sat_acc(input logic signed [WIDTH+1:0] a);
        if (a > A_MAX)      return W_MAX;
        else if (a < A_MIN) return W_MIN;
        else                return a[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] t);
        if (t == W_MIN)              return W_MAX;
        else if (t[WIDTH-1] == 1'b1) return -t;
        else                         return t;
    endfunction

    logic signed [WIDTH-1:0] r_x;
    logic signed [X2W-1:0]   r_x2;
    logic signed [WIDTH-1:0] r_term;
    logic signed [WIDTH+1:0] r_acc;
    logic [3:0]              r_k;
    logic signed [WIDTH-1:0] r_cos;
    logic signed [WIDTH-1:0] r_err;
    logic                    r_done;

    logic signed [TW-1:0]    w_xx;
    logic signed [TW-1:0]    w_tx;
    logic signed [PW-1:0]    w_p;
    logic signed [WIDTH-1:0] w_recip;
    logic signed [RW-1:0]    w_pr;
    logic signed [WIDTH-1:0] w_term_nxt;
    logic                    w_unused;

    // Floor shift followed by truncation equals a bit slice of the full product.
    assign w_xx       = TW'(r_x) * TW'(r_x);
    assign w_tx       = TW'(r_term) * TW'(r_x2);
    assign w_p        = w_tx[TW-1:FRAC];
    assign w_recip    = RECIP[r_k];
    assign w_pr       = RW'(w_p) * RW'(w_recip);
    assign w_term_nxt = -w_pr[RW-1:FRAC];
    assign w_unused   = &{1'b0, w_xx[TW-1:FRAC+X2W], w_xx[FRAC-1:0], w_tx[FRAC-1:0], w_pr[FRAC-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_x2   <= '0;
            r_term <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_cos  <= '0;
            r_err  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (bus.state)
                ST_ALERT: r_x <= bus.x_in;
                ST_START: begin
                    r_x2   <= w_xx[FRAC+X2W-1:FRAC];
                    r_term <= ONE;
                    r_acc  <= '0;
                    r_k    <= '0;
                end
                ST_ACCUM: begin
                    if (r_k < K_LAST) begin
                        r_acc  <= r_acc + (WIDTH+2)'(r_term);
                        r_term <= w_term_nxt;
                        r_k    <= r_k + 4'd1;
                    end
                end
                ST_PUBLISH: begin
                    r_cos  <= sat_acc(r_acc);
                    r_err  <= abs_sat(r_term);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.stop    = (bus.state == ST_ACCUM) && (r_k == K_LAST);
    assign bus.cos_out = r_cos;
    assign bus.err_out = r_err;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_cosine_datapath.sv
// Self-checking bench for cosine_datapath: spec vector table, randomized operands against
// a plain-integer series model, and hand sequences for stop timing, reset abort and illegal states.
module tb_cosine_datapath;
    localparam int WIDTH   = 18;
    localparam int FRAC    = 14;
    localparam int N_TERMS = 8;
    localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (WIDTH - 1));

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cosine_datapath_if #(.WIDTH(WIDTH)) bus ();

    cosine_datapath #(.WIDTH(WIDTH), .FRAC(FRAC), .N_TERMS(N_TERMS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int exp_cos;
        int tol;
        int err_max;
    } vec_t;

    vec_t   vecs[5];
    int     recip_m[N_TERMS];
    int     n_checks = 0;
    int     n_err    = 0;
    longint c_a, e_a, c_b, e_b, mc, me;
    int     n;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
        n_checks++;
        if (act < exp - tol || act > exp + tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic check_max(input string name, input longint act, input longint lim);
        n_checks++;
        if (act < 0 || act > lim) begin
            n_err++;
            $display("FAIL %s: got %0d expected 0..%0d", name, act, lim);
        end
    endtask

    // Sum of the first N_TERMS series terms, computed in 64-bit integers.
    function automatic void model(input int x, output longint c, output longint e);
        longint x2, t, acc, p;
        x2  = (longint'(x) * longint'(x)) >>> FRAC;
        t   = 64'sd1 <<< FRAC;
        acc = 0;
        for (int k = 0; k < N_TERMS; k++) begin
            acc += t;
            p = (t * x2) >>> FRAC;
            t = -((p * recip_m[k]) >>> FRAC);
        end
        c = (acc > MAXV) ? MAXV : (acc < MINV) ? MINV : acc;
        e = (t < 0) ? -t : t;
        if (e > MAXV) e = MAXV;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int x);
        bus.state = 3'd1;
        bus.x_in  = WIDTH'($urandom_range(0, 2000) - 1000);
        tick();
        bus.x_in  = WIDTH'(x);
        tick();
        bus.state = 3'd2;
        bus.x_in  = WIDTH'($urandom_range(0, 2000) - 1000);
        tick();
    endtask

    task automatic wait_stop(input string name, input int exp_ticks);
        int cnt = 0;
        while (bus.stop !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check(name, cnt, exp_ticks);
    endtask

    task automatic run_calc(input int x, input string tag, output longint c, output longint e);
        longint m_c, m_e;
        model(x, m_c, m_e);
        load(x);
        bus.state = 3'd3;
        #1;
        wait_stop({tag, "_stop_ticks"}, N_TERMS);
        bus.state = 3'd4;
        tick();
        check({tag, "_done"}, longint'(bus.done), 1);
        check({tag, "_cos"}, longint'(bus.cos_out), m_c);
        check({tag, "_err"}, longint'(bus.err_out), m_e);
        c = longint'(bus.cos_out);
        e = longint'(bus.err_out);
        bus.state = 3'd0;
        tick();
        check({tag, "_done_pulse"}, longint'(bus.done), 0);
        check({tag, "_cos_hold"}, longint'(bus.cos_out), m_c);
    endtask

    initial begin
        vecs[0] = '{x: 0,      exp_cos: 16384,  tol: 0, err_max: 0};
        vecs[1] = '{x: 16384,  exp_cos: 8852,   tol: 3, err_max: 3};
        vecs[2] = '{x: -16384, exp_cos: 8852,   tol: 3, err_max: 3};
        vecs[3] = '{x: 51472,  exp_cos: -16384, tol: 8, err_max: 8};
        vecs[4] = '{x: -51472, exp_cos: -16384, tol: 8, err_max: 8};
        for (int k = 0; k < N_TERMS; k++)
            recip_m[k] = int'((2.0 ** FRAC) / real'((2 * k + 1) * (2 * k + 2)));

        rst_n     = 1'b0;
        bus.state = 3'd0;
        bus.x_in  = '0;
        #2;
        check("rst_cos", longint'(bus.cos_out), 0);
        check("rst_err", longint'(bus.err_out), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_stop", longint'(bus.stop), 0);
        #10 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_calc(vecs[i].x, $sformatf("vec%0d", i), c_a, e_a);
            check_tol($sformatf("vec%0d_cos_spec", i), c_a, vecs[i].exp_cos, vecs[i].tol);
            check_max($sformatf("vec%0d_err_spec", i), e_a, vecs[i].err_max);
        end

        run_calc(16384, "sym_pos", c_a, e_a);
        run_calc(-16384, "sym_neg", c_b, e_b);
        check("even_symmetry", c_b, c_a);

        for (int i = 0; i < 12; i++) begin
            run_calc(int'($urandom_range(0, 104000)) - 52000, $sformatf("rnd%0d", i), c_a, e_a);
        end

        // Stop timing: hold state 3 for 12 cycles.
        model(16384, mc, me);
        load(16384);
        bus.state = 3'd3;
        #1;
        for (int i = 1; i <= 12; i++) begin
            check($sformatf("stop_cyc%0d", i), longint'(bus.stop), (i >= N_TERMS + 1) ? 1 : 0);
            tick();
        end
        bus.state = 3'd4;
        #1;
        check("stop_in_st4", longint'(bus.stop), 0);
        tick();
        check("stop_hold_cos", longint'(bus.cos_out), mc);
        check("stop_hold_err", longint'(bus.err_out), me);
        bus.state = 3'd0;
        #1;
        check("stop_in_st0", longint'(bus.stop), 0);
        tick();

        // Illegal state 6 mid-accumulation must freeze k and acc.
        load(16384);
        bus.state = 3'd3;
        #1;
        repeat (3) tick();
        bus.state = 3'd6;
        #1;
        check("ill_stop", longint'(bus.stop), 0);
        repeat (3) tick();
        check("ill_done", longint'(bus.done), 0);
        check("ill_cos_hold", longint'(bus.cos_out), mc);
        bus.state = 3'd3;
        #1;
        wait_stop("ill_resume_ticks", N_TERMS - 3);
        bus.state = 3'd4;
        tick();
        check("ill_cos", longint'(bus.cos_out), mc);
        check("ill_done_pub", longint'(bus.done), 1);
        bus.state = 3'd0;
        tick();

        // Reset asserted mid-computation aborts and clears everything at once.
        load(51472);
        bus.state = 3'd3;
        #1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("abort_cos", longint'(bus.cos_out), 0);
        check("abort_err", longint'(bus.err_out), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_stop", longint'(bus.stop), 0);
        bus.state = 3'd0;
        #2 rst_n = 1'b1;
        tick();
        run_calc(0, "rerun0", c_a, e_a);
        check("rerun0_cos_one", c_a, 16384);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
